// File: rtl/proc_sched_pkg.sv
// proc_sched_pkg: shared constants and types for the proc scheduler.
//   ST_*          FSM state encodings (IDLE, PKT_START, PKT_WAIT, CFG_APPLY, CFG_SETTLE)
//   cfg_target_e  reconfiguration target (CFG_PROC..CFG_EXEC)
//   CNT_W         width of the completion counters
//   mod_onehot()  target -> one-hot {exec, matcher, parser, proc} mod-start vector
package proc_sched_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned ST_W  = 3;

  localparam logic [ST_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [ST_W-1:0] ST_PKT_START  = 3'd1;
  localparam logic [ST_W-1:0] ST_PKT_WAIT   = 3'd2;
  localparam logic [ST_W-1:0] ST_CFG_APPLY  = 3'd3;
  localparam logic [ST_W-1:0] ST_CFG_SETTLE = 3'd4;

  typedef enum logic [1:0] {
    CFG_PROC    = 2'd0,
    CFG_PARSER  = 2'd1,
    CFG_MATCHER = 2'd2,
    CFG_EXEC    = 2'd3
  } cfg_target_e;

  // Bit 0 = proc, 1 = parser, 2 = matcher, 3 = exec.
  function automatic logic [3:0] mod_onehot(input logic [1:0] tgt);
    return 4'(1) << tgt;
  endfunction

endpackage

// File: rtl/proc_sched_wdog.sv
// proc_sched_wdog: busy-cycle watchdog for one packet in flight.
//   clk, rst   clock, synchronous active-low reset
//   clr        clear the count (packet just started)
//   en         count this cycle (waiting for proc completion)
//   fire_c     combinational: this is the TIMEOUT_CYCLES-th enabled cycle
module proc_sched_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic fire_c
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  // Count enabled cycles; hold once firing since the scheduler leaves the wait state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !fire_c) begin
      cnt <= cnt + W'(1);
    end
  end

  assign fire_c = en && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/proc_sched.sv
// proc_sched: sequences one proc instance. Admits packets, issues proc start and waits
// for completion; serialises reconfiguration (mod starts) so they only land while proc
// is idle; arbitrates packets vs configs with a bounded config burst.
// Optional watchdog: define PROC_SCHED_WDOG_EN.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   pkt_valid_i/pkt_ready_o        packet request / accept (ready combinational)
//   pkt_done_o                     pulse when the accepted packet finishes
//   cfg_valid_i/cfg_target_i       config request and target (held until cfg_done_o)
//   cfg_ready_o                    config accept (combinational)
//   cfg_done_o                     pulse when settle completes
//   proc_start_o, proc_ready_i     proc handshake
//   proc/ps/mt/ex_mod_start_o      one-cycle reconfiguration strobes
//   pkt_cnt_o, cfg_cnt_o           wrapping completion counters
//   pkt_timeout_o, proc_flush_o    watchdog pulses (0 without PROC_SCHED_WDOG_EN)
import proc_sched_pkg::*;

module proc_sched #(
  parameter int unsigned MAX_CFG_BURST     = 4,
  parameter int unsigned CFG_SETTLE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_valid_i,
  output logic             pkt_ready_o,
  output logic             pkt_done_o,
  input  logic             cfg_valid_i,
  input  logic [1:0]       cfg_target_i,
  output logic             cfg_ready_o,
  output logic             cfg_done_o,
  output logic             proc_start_o,
  input  logic             proc_ready_i,
  output logic             proc_mod_start_o,
  output logic             ps_mod_start_o,
  output logic             mt_mod_start_o,
  output logic             ex_mod_start_o,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic [CNT_W-1:0] cfg_cnt_o,
  output logic             pkt_timeout_o,
  output logic             proc_flush_o
);

  localparam int unsigned BURST_W  = $clog2(MAX_CFG_BURST + 1);
  localparam int unsigned SETTLE_W = 8;

  // Reject parameter values the counters cannot represent.
  if (CFG_SETTLE_CYCLES == 0 || CFG_SETTLE_CYCLES > 255 || TIMEOUT_CYCLES == 0) begin : g_param_chk
    $error("proc_sched: CFG_SETTLE_CYCLES must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  logic [ST_W-1:0]     state, state_nxt;
  logic [BURST_W-1:0]  burst_cnt, burst_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic                start_nxt, pdone_nxt, cdone_nxt, tout_nxt, pkt_inc, cfg_inc;
  logic [3:0]          mod_nxt;
  logic                wdog_fire_c;

`ifdef PROC_SCHED_WDOG_EN
  proc_sched_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == ST_PKT_START),
    .en    (state == ST_PKT_WAIT),
    .fire_c(wdog_fire_c)
  );
`else
  assign wdog_fire_c = 1'b0;
`endif

  // Next state, arbitration and next values of the registered strobes.
  always_comb begin
    state_nxt   = state;
    burst_nxt   = burst_cnt;
    settle_nxt  = settle_cnt;
    pkt_ready_o = 1'b0;
    cfg_ready_o = 1'b0;
    start_nxt   = 1'b0;
    mod_nxt     = 4'b0;
    pdone_nxt   = 1'b0;
    cdone_nxt   = 1'b0;
    tout_nxt    = 1'b0;
    pkt_inc     = 1'b0;
    cfg_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        // Config wins unless it has used up its burst while a packet waits.
        if (cfg_valid_i && !(pkt_valid_i && burst_cnt == BURST_W'(MAX_CFG_BURST))) begin
          cfg_ready_o = 1'b1;
          mod_nxt     = mod_onehot(cfg_target_i);
          state_nxt   = ST_CFG_APPLY;
          if (burst_cnt != BURST_W'(MAX_CFG_BURST)) begin
            burst_nxt = burst_cnt + BURST_W'(1);
          end
        end else if (pkt_valid_i) begin
          pkt_ready_o = 1'b1;
          start_nxt   = 1'b1;
          burst_nxt   = '0;
          state_nxt   = ST_PKT_START;
        end
      end
      ST_PKT_START: begin
        state_nxt = ST_PKT_WAIT;
      end
      ST_PKT_WAIT: begin
        // A completion on the watchdog's last cycle still counts as normal.
        if (proc_ready_i) begin
          pdone_nxt = 1'b1;
          pkt_inc   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wdog_fire_c) begin
          pdone_nxt = 1'b1;
          tout_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_CFG_APPLY: begin
        settle_nxt = SETTLE_W'(CFG_SETTLE_CYCLES - 1);
        state_nxt  = ST_CFG_SETTLE;
      end
      ST_CFG_SETTLE: begin
        if (settle_cnt == '0) begin
          cdone_nxt = 1'b1;
          cfg_inc   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          settle_nxt = settle_cnt - SETTLE_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered output strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= ST_IDLE;
      burst_cnt        <= '0;
      settle_cnt       <= '0;
      proc_start_o     <= 1'b0;
      proc_mod_start_o <= 1'b0;
      ps_mod_start_o   <= 1'b0;
      mt_mod_start_o   <= 1'b0;
      ex_mod_start_o   <= 1'b0;
      pkt_done_o       <= 1'b0;
      cfg_done_o       <= 1'b0;
      pkt_timeout_o    <= 1'b0;
      proc_flush_o     <= 1'b0;
      pkt_cnt_o        <= '0;
      cfg_cnt_o        <= '0;
    end else begin
      state            <= state_nxt;
      burst_cnt        <= burst_nxt;
      settle_cnt       <= settle_nxt;
      proc_start_o     <= start_nxt;
      proc_mod_start_o <= mod_nxt[0];
      ps_mod_start_o   <= mod_nxt[1];
      mt_mod_start_o   <= mod_nxt[2];
      ex_mod_start_o   <= mod_nxt[3];
      pkt_done_o       <= pdone_nxt;
      cfg_done_o       <= cdone_nxt;
      pkt_timeout_o    <= tout_nxt;
      proc_flush_o     <= tout_nxt;
      if (pkt_inc) begin
        pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
      end
      if (cfg_inc) begin
        cfg_cnt_o <= cfg_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
